// File: rtl/noc_pkg.sv
// ---------------------------------------------------------------------------
// noc_pkg
//
// Shared definitions for the NoC input-port slice.
//
//   DATA_WIDTH_DEF : default flit width in bits
//   DEST_WIDTH     : width of the destination node index inside a flit
//   DEST_LSB       : bit position of the destination node index
//   hs_state_e     : upstream 4-phase handshake states (IDLE, ACK)
// ---------------------------------------------------------------------------
package noc_pkg;

   localparam int DATA_WIDTH_DEF = 37;

   // Destination node index occupies flit bits [3:0]
   localparam int DEST_WIDTH = 4;
   localparam int DEST_LSB   = 0;

   // IDLE waits for a request; ACK holds the acknowledge until the request drops
   typedef enum logic {
      IDLE = 1'b0,
      ACK  = 1'b1
   } hs_state_e;

endpackage

// File: rtl/noc_fifo.sv
// ---------------------------------------------------------------------------
// noc_fifo
//
// Flit buffer for one NoC input port. Circular buffer of DEPTH entries with
// wrapping read/write pointers, an occupancy counter one bit wider than the
// pointers, registered read data and registered empty/full flags.
//
// The flags are decoded from the occupancy held before each edge, so they
// lag the counter by one cycle: empty falls on the edge after the first
// write, and full falls on the edge after the pop that made room.
//
// Parameters:
//   DATA_WIDTH : flit width
//   DEPTH      : number of entries, power of two, at least 2
//
// Ports:
//   clk     : clock, all state changes on the rising edge
//   reset   : asynchronous active-low reset
//   wr_en   : push wr_data at the tail (caller guarantees full is low)
//   wr_data : flit to push
//   rd_req  : pop request from the downstream routing stage
//   rd_data : registered head flit from the most recent successful pop
//   empty   : registered, high when the buffer holds no flits
//   full    : registered, high when the buffer holds DEPTH flits
// ---------------------------------------------------------------------------
module noc_fifo
   import noc_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_req,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  empty,
   output logic                  full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                  empty_q, empty_d;
   logic                  full_q, full_d;
   logic                  pop;

   // Because empty lags the counter, it can still read 0 for one cycle after
   // the last flit left; the counter check keeps a pop in that window from
   // underflowing the buffer.
   always_comb begin
      pop       = rd_req && !empty_q && (count_q != '0);

      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      rd_data_d = rd_data_q;
      count_d   = count_q;

      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end

      if (pop) begin
         rd_ptr_d  = rd_ptr_q + PTR_ONE;
         rd_data_d = mem_q[rd_ptr_q];
      end

      case ({wr_en, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase

      empty_d = (count_q == '0);
      full_d  = (count_q == CNT_FULL);
   end

   // Pointer, counter, flag and read-data registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         rd_data_q <= '0;
         empty_q   <= 1'b1;
         full_q    <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         rd_data_q <= rd_data_d;
         empty_q   <= empty_d;
         full_q    <= full_d;
      end
   end

   // Storage array; contents are don't-care until written, so no reset
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   assign rd_data = rd_data_q;
   assign empty   = empty_q;
   assign full    = full_q;

endmodule

// File: rtl/in_port.sv
// ---------------------------------------------------------------------------
// in_port
//
// NoC router input port. A 4-phase handshake FSM accepts flits from the
// upstream neighbour's output stage and pushes them into a noc_fifo; the
// downstream routing stage pops them with rdreq.
//
// Handshake: in IDLE a request (inr=1) is accepted on the first edge where
// full=0 -- the flit is written and inw rises on that edge. In ACK, inw
// stays high until inr drops, so a long request still writes one flit.
//
// Optional feature (macro IN_PORT_STATS_EN): adds output flit_cnt, a 16-bit
// wrapping count of accepted flits.
//
// Parameters:
//   DATA_WIDTH : flit width, bits [3:0] carry the destination node index
//   DEPTH      : FIFO entries, power of two, at least 2
//
// Ports:
//   clk       : clock
//   reset     : asynchronous active-low reset
//   inr       : request from upstream
//   data_in   : flit from upstream, valid while inr=1
//   inw       : acknowledge to upstream (registered)
//   rdreq     : read strobe from downstream
//   data_fifo : registered FIFO read data
//   empty     : FIFO holds no flits (registered)
//   full      : FIFO holds DEPTH flits (registered)
//   flit_cnt  : accepted-flit counter (IN_PORT_STATS_EN only)
// ---------------------------------------------------------------------------
module in_port
   import noc_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  inr,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic                  inw,
   input  logic                  rdreq,
   output logic [DATA_WIDTH-1:0] data_fifo,
   output logic                  empty,
   output logic                  full
`ifdef IN_PORT_STATS_EN
   ,
   output logic [15:0]           flit_cnt
`endif
);

   hs_state_e state_q, state_d;
   logic      inw_q, inw_d;
   logic      wr_en;
   logic      fifo_full;

   // Handshake next-state: the write strobe fires only on the IDLE->ACK
   // transition, which is what limits each handshake to a single flit.
   always_comb begin
      state_d = state_q;
      inw_d   = inw_q;
      wr_en   = 1'b0;

      case (state_q)
         IDLE: begin
            inw_d = 1'b0;
            if (inr && !fifo_full) begin
               wr_en   = 1'b1;
               inw_d   = 1'b1;
               state_d = ACK;
            end
         end
         ACK: begin
            inw_d = 1'b1;
            if (!inr) begin
               inw_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            inw_d   = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // Handshake state and registered acknowledge
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         inw_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         inw_q   <= inw_d;
      end
   end

   assign inw  = inw_q;
   assign full = fifo_full;

   noc_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_data (data_in),
      .rd_req  (rdreq),
      .rd_data (data_fifo),
      .empty   (empty),
      .full    (fifo_full)
   );

`ifdef IN_PORT_STATS_EN
   logic [15:0] flit_cnt_q, flit_cnt_d;

   // Counts accepted flits; natural 16-bit overflow gives the 0xFFFF -> 0 wrap
   always_comb begin
      flit_cnt_d = flit_cnt_q;
      if (wr_en) begin
         flit_cnt_d = flit_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         flit_cnt_q <= '0;
      end else begin
         flit_cnt_q <= flit_cnt_d;
      end
   end

   assign flit_cnt = flit_cnt_q;
`endif

endmodule

// File: tb/tb_in_port.sv
// ---------------------------------------------------------------------------
// tb_in_port
//
// Self-checking bench for in_port (DATA_WIDTH=37, DEPTH=4). A queue-based
// reference model predicts every output after every clock edge; a short
// table of hand-derived vectors, a few directed sequences and a randomized
// run are all checked against it. Define IN_PORT_STATS_EN to also check
// flit_cnt.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_in_port;

   localparam int DW    = 37;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          inr;
   logic [DW-1:0] data_in;
   logic          inw;
   logic          rdreq;
   logic [DW-1:0] data_fifo;
   logic          empty;
   logic          full;
`ifdef IN_PORT_STATS_EN
   logic [15:0]   flit_cnt;
`endif

   int total = 0;
   int bad   = 0;

   // Reference model state: stored flits in arrival order, whether an
   // acknowledge is currently being held, and the expected output values.
   logic [DW-1:0] mQueue[$];
   bit            mBusy;
   bit            mEmpty;
   bit            mFull;
   logic [DW-1:0] mData;
   logic [15:0]   mCnt;

   typedef struct {
      bit            vInr;
      logic [DW-1:0] vDin;
      bit            vRd;
      bit            eInw;
      bit            eEmpty;
      bit            eFull;
      logic [DW-1:0] eData;
   } vec_t;

   vec_t vecs[7];

   in_port #(
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .inr       (inr),
      .data_in   (data_in),
      .inw       (inw),
      .rdreq     (rdreq),
      .data_fifo (data_fifo),
      .empty     (empty),
      .full      (full)
`ifdef IN_PORT_STATS_EN
      ,
      .flit_cnt  (flit_cnt)
`endif
   );

   // Free-running 100 MHz clock
   always #5 clk = ~clk;

   // Guards against a hang anywhere in the sequence
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison: counts it and reports any difference
   task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Compares every DUT output with the reference model
   task automatic checkOutput(input string tag);
      checkValue({tag, ".inw"},       64'(inw),       64'(mBusy));
      checkValue({tag, ".empty"},     64'(empty),     64'(mEmpty));
      checkValue({tag, ".full"},      64'(full),      64'(mFull));
      checkValue({tag, ".data_fifo"}, 64'(data_fifo), 64'(mData));
`ifdef IN_PORT_STATS_EN
      checkValue({tag, ".flit_cnt"},  64'(flit_cnt),  64'(mCnt));
`endif
   endtask

   // Model after reset: nothing stored, no acknowledge, flags idle
   task automatic modelReset();
      mQueue.delete();
      mBusy  = 1'b0;
      mEmpty = 1'b1;
      mFull  = 1'b0;
      mData  = '0;
      mCnt   = '0;
   endtask

   // Drives one cycle of inputs, advances the model over the edge and checks.
   // Flags report the occupancy as it stood before the edge; a read pops only
   // when the flag says non-empty and something is actually stored.
   task automatic applyStimulus(input bit iInr, input logic [DW-1:0] iDin, input bit iRd,
                                input string tag);
      int occ;
      bit accept;
      bit popIt;
      inr     = iInr;
      data_in = iDin;
      rdreq   = iRd;
      @(posedge clk);
      occ    = mQueue.size();
      accept = !mBusy && iInr && !mFull;
      popIt  = iRd && !mEmpty && (occ > 0);
      if (popIt) mData = mQueue.pop_front();
      if (accept) begin
         mQueue.push_back(iDin);
         mCnt = mCnt + 16'd1;
      end
      mBusy  = accept || (mBusy && iInr);
      mEmpty = (occ == 0);
      mFull  = (occ == DEPTH);
      #1;
      checkOutput(tag);
   endtask

   // Asserts reset mid-cycle, checks the immediate effect, holds it for two
   // edges and releases it just after an edge.
   task automatic applyReset(input string tag);
      reset = 1'b0;
      #1;
      modelReset();
      checkOutput({tag, ".async"});
      repeat (2) @(posedge clk);
      #1;
      checkOutput({tag, ".held"});
      reset = 1'b1;
   endtask

   // One full 4-phase handshake with a bounded wait for the acknowledge
   task automatic doHandshake(input logic [DW-1:0] din, input bit rdFirst, input string tag);
      int n;
      n = 0;
      applyStimulus(1'b1, din, rdFirst, {tag, ".req"});
      while (!inw && n < 20) begin
         applyStimulus(1'b1, din, 1'b0, {tag, ".wait"});
         n++;
      end
      if (!inw) begin
         total++;
         bad++;
         $display("[TB] FAIL %s.timeout: got inw=%0b, expected 1", tag, inw);
      end
      applyStimulus(1'b0, din, 1'b0, {tag, ".drop"});
   endtask

   initial begin
      reset   = 1'b1;
      inr     = 1'b0;
      data_in = '0;
      rdreq   = 1'b0;
      modelReset();

      // Hand-derived single-flit walk: write 0x25, drop request, pop, then
      // read while empty (data must hold)
      vecs[0] = '{1'b1, 37'h25, 1'b0, 1'b1, 1'b1, 1'b0, 37'h0};
      vecs[1] = '{1'b1, 37'h25, 1'b0, 1'b1, 1'b0, 1'b0, 37'h0};
      vecs[2] = '{1'b0, 37'h0,  1'b0, 1'b0, 1'b0, 1'b0, 37'h0};
      vecs[3] = '{1'b0, 37'h0,  1'b1, 1'b0, 1'b0, 1'b0, 37'h25};
      vecs[4] = '{1'b0, 37'h0,  1'b0, 1'b0, 1'b1, 1'b0, 37'h25};
      vecs[5] = '{1'b0, 37'h0,  1'b1, 1'b0, 1'b1, 1'b0, 37'h25};
      vecs[6] = '{1'b0, 37'h0,  1'b0, 1'b0, 1'b1, 1'b0, 37'h25};

      #2;
      applyReset("rst0");

      for (int i = 0; i < 7; i++) begin
         applyStimulus(vecs[i].vInr, vecs[i].vDin, vecs[i].vRd, $sformatf("vec%0d", i));
         checkValue($sformatf("vec%0d.tbl_inw", i),   64'(inw),       64'(vecs[i].eInw));
         checkValue($sformatf("vec%0d.tbl_empty", i), 64'(empty),     64'(vecs[i].eEmpty));
         checkValue($sformatf("vec%0d.tbl_full", i),  64'(full),      64'(vecs[i].eFull));
         checkValue($sformatf("vec%0d.tbl_data", i),  64'(data_fifo), 64'(vecs[i].eData));
      end

      // Fill to full, a fifth request must wait for a pop
      applyReset("rst1");
      for (int i = 0; i < DEPTH; i++) begin
         doHandshake(37'h100 + 37'(i), 1'b0, $sformatf("fill%0d", i));
      end
      checkValue("full_after_fill", 64'(full), 64'(1));
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 37'h105, 1'b0, "blocked");
         checkValue("blocked_inw", 64'(inw), 64'(0));
      end
      applyStimulus(1'b1, 37'h105, 1'b1, "pop_room");
      checkValue("pop_room_data", 64'(data_fifo), 64'h100);
      applyStimulus(1'b1, 37'h105, 1'b0, "full_clear");
      checkValue("full_clears", 64'(full), 64'(0));
      applyStimulus(1'b1, 37'h105, 1'b0, "fifth_ack");
      checkValue("fifth_ack_inw", 64'(inw), 64'(1));
      applyStimulus(1'b0, 37'h0, 1'b0, "fifth_drop");

      // Occupancy 2, then writes paired with pops across the pointer wrap,
      // then drain; every popped flit is compared in order
      applyReset("rst2");
      doHandshake(37'h10, 1'b0, "wrap0");
      doHandshake(37'h11, 1'b0, "wrap1");
      for (int i = 2; i < 10; i++) begin
         doHandshake(37'h10 + 37'(i), 1'b1, $sformatf("wrap%0d", i));
         checkValue($sformatf("wrap%0d.not_empty", i), 64'(empty), 64'(0));
         checkValue($sformatf("wrap%0d.head", i), 64'(data_fifo), 64'h10 + 64'(i - 2));
      end
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b0, 37'h0, 1'b1, "drain");
      end
      checkValue("drain_last", 64'(data_fifo), 64'h19);
      checkValue("drain_empty", 64'(empty), 64'(1));

      // Reset while acknowledging the third stored flit; the held request
      // must be accepted again as a new one after release
      applyReset("rst3");
      doHandshake(37'h31, 1'b0, "mid0");
      doHandshake(37'h32, 1'b0, "mid1");
      applyStimulus(1'b1, 37'h33, 1'b0, "mid2.req");
      applyStimulus(1'b1, 37'h33, 1'b0, "mid2.hold");
      checkValue("mid2_in_ack", 64'(inw), 64'(1));
      applyReset("rst_mid");
      checkValue("rst_mid_inw", 64'(inw), 64'(0));
      checkValue("rst_mid_empty", 64'(empty), 64'(1));
      applyStimulus(1'b1, 37'h33, 1'b0, "post_rst.req");
      checkValue("post_rst_ack", 64'(inw), 64'(1));
      applyStimulus(1'b0, 37'h0, 1'b0, "post_rst.drop");
      applyStimulus(1'b0, 37'h0, 1'b1, "post_rst.pop");
      applyStimulus(1'b0, 37'h0, 1'b0, "post_rst.idle");
      checkValue("post_rst_data", 64'(data_fifo), 64'h33);

      // Randomized traffic: request and read strobes driven independently
      for (int i = 0; i < 600; i++) begin
         applyStimulus(($urandom_range(0, 9) < 6),
                       {5'($urandom), 32'($urandom)},
                       ($urandom_range(0, 9) < 4),
                       "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/in_port.md
IN_PORT -- requirements
Module: in_port

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 37, flit width; bits [3:0] are the destination node index.
REQ-002 SHALL have parameter DEPTH, default 4, FIFO entries; power of two, at least 2.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, asynchronous active-low reset: asserted when 0, released synchronously to clk.
REQ-005 SHALL have port inr, input, 1 bit, request from the upstream neighbour's output stage.
REQ-006 SHALL have port data_in, input, DATA_WIDTH bits, flit from upstream; valid whenever inr=1.
REQ-007 SHALL have port inw, output, 1 bit, acknowledge returned to upstream.
REQ-008 SHALL have port rdreq, input, 1 bit, read strobe from the downstream routing stage.
REQ-009 SHALL have port data_fifo, output, DATA_WIDTH bits, registered FIFO read data.
REQ-010 SHALL have port empty, output, 1 bit, asserted when the FIFO holds 0 flits.
REQ-011 SHALL have port full, output, 1 bit, asserted when the FIFO holds DEPTH flits.

Function
REQ-012 SHALL run a 4-phase handshake FSM with states IDLE and ACK.
REQ-013 In IDLE with inr=1 and full=0, SHALL write data_in to the FIFO tail, set inw=1 and enter ACK on the same edge.
REQ-014 In IDLE with inr=1 and full=1, SHALL hold inw=0 and write nothing until full=0; the flit is accepted on the first edge where full=0.
REQ-015 In ACK, SHALL hold inw=1 while inr=1; when inr=0, SHALL clear inw and return to IDLE.
REQ-016 SHALL write exactly one flit per handshake, regardless of how long inr stays high in ACK.
REQ-017 rdreq=1 with empty=0 SHALL pop the head; data_fifo SHALL show that flit from the next edge and hold it until the next successful pop.
REQ-018 rdreq=1 with empty=1 SHALL be ignored: no pointer change, data_fifo unchanged.
REQ-019 A write and a pop on the same edge SHALL both take effect and leave the occupancy unchanged; on a full FIFO the write is blocked per REQ-014.
REQ-020 Pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; occupancy SHALL be held in a log2(DEPTH)+1 bit counter.
REQ-021 empty and full SHALL be registered and decoded from the occupancy counter, with no combinational path from inputs.
REQ-022 Write-to-empty-deassert latency SHALL be 1 cycle: empty falls on the edge after the write edge.

Reset
REQ-023 While reset=0, SHALL force the FSM to IDLE, inw=0, pointers=0, occupancy=0, empty=1, full=0 and data_fifo=0.
REQ-024 Reset mid-handshake SHALL discard all stored flits and any in-progress acknowledge; after release, a still-high inr is treated as a new request.

Configuration
REQ-025 With macro IN_PORT_STATS_EN defined, SHALL add output flit_cnt, 16 bits, incremented on each accepted write, wrapping at 0xFFFF to 0, and reset to 0.
REQ-026 Without IN_PORT_STATS_EN, flit_cnt and its counter SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-027 Package noc_pkg SHALL hold the DATA_WIDTH default, the destination-field width and position (4 bits at [3:0]), and the handshake state encoding (IDLE, ACK).
REQ-028 FIFO storage, pointers and flags SHALL live in sub-module noc_fifo; in_port SHALL contain the handshake FSM and the optional counter.

Verification
REQ-029 Reset, then inr=1 with data_in=0x0_0000_0025 -> inw=1 one edge later, empty=0 on the following edge; drop inr -> inw=0 next edge; rdreq pulse -> data_fifo=0x0_0000_0025, empty=1.
REQ-030 With DEPTH=4, run 4 handshakes with no reads -> full=1; a 5th inr=1 -> inw stays 0; one rdreq -> full=0 and the 5th flit is acknowledged on the next edge.
REQ-031 rdreq=1 while empty=1 -> data_fifo holds its prior value and occupancy stays 0.
REQ-032 Occupancy 2, write and rdreq on the same edge -> occupancy stays 2, and flits pop in FIFO order across the pointer wrap (write 10 flits, read 10, values match).
REQ-033 Assert reset=0 while in ACK with 3 flits stored -> inw=0, empty=1 immediately; with IN_PORT_STATS_EN defined, flit_cnt=0 and then counts 0xFFFF -> 0 on wrap.
